// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forwarding encodings, md sequencer states and default
// multiply/divide latencies for the pipeline hazard controller.
package hazard_pkg;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam int DEF_MUL_CYCLES = 4;
    localparam int DEF_DIV_CYCLES = 32;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
endpackage

// File: rtl/md_sequencer.sv
// md_sequencer: tracks the multi-cycle multiply/divide unit; done pulses
// exactly MUL_CYCLES/DIV_CYCLES cycles after an accepted start.
module md_sequencer
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);
    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The start cycle and the DONE cycle account for two of the latency cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = BUSY;
                cnt_d   = is_div ? CNT_W'(DIV_CYCLES - 2) : CNT_W'(MUL_CYCLES - 2);
            end
            BUSY: begin
                cnt_d   = cnt_q == '0 ? '0 : cnt_q - CNT_W'(1);
                state_d = cnt_q == '0 ? DONE : BUSY;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/PC-hold priority logic, EX forwarding
// selects and HI/LO interlock for the 5-stage MIPS pipeline.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES,
    parameter int CNT_W      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_md_access,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              ex_md_start,
    input  logic              ex_md_is_div,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_reg_write,
    input  logic              wb_reg_write,
    input  logic              mem_wait,
    output logic              pc_stall,
    output logic              stall_ifid,
    output logic              flush_ifid,
    output logic              stall_idex,
    output logic              flush_idex,
    output logic              stall_exmem,
    output logic              flush_exmem,
    output logic              stall_memwb,
    output logic              flush_memwb,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              md_busy,
    output logic              md_done
);
    logic load_use, md_lock, freeze, redirect, bubble;

    md_sequencer #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES),
        .CNT_W     (CNT_W)
    ) u_md (
        .clk   (clk),
        .reset (reset),
        .start (ex_md_start && !mem_wait && !ex_branch_taken),
        .is_div(ex_md_is_div),
        .busy  (md_busy),
        .done  (md_done)
    );

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        if (mem_reg_write && mem_rd != '0 && mem_rd == src) return FWD_MEM;
        if (wb_reg_write && wb_rd != '0 && wb_rd == src) return FWD_WB;
        return FWD_RF;
    endfunction

    assign load_use = ex_mem_read && ex_rd != '0 &&
                      ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    assign md_lock  = id_md_access && (md_busy || ex_md_start);

    // A taken branch squashes the ID instruction, so it outranks both interlocks.
    assign freeze   = !reset && mem_wait;
    assign redirect = !reset && !mem_wait && ex_branch_taken;
    assign bubble   = !reset && !mem_wait && !ex_branch_taken && (load_use || md_lock);

    assign pc_stall    = freeze || bubble;
    assign stall_ifid  = freeze || bubble;
    assign flush_ifid  = redirect;
    assign stall_idex  = freeze;
    assign flush_idex  = redirect || bubble;
    assign stall_exmem = freeze;
    assign flush_exmem = 1'b0;
    assign stall_memwb = freeze;
    assign flush_memwb = 1'b0;

    always_comb begin
        fwd_a = reset ? FWD_RF : fwd_sel(ex_rs);
        fwd_b = reset ? FWD_RF : fwd_sel(ex_rt);
    end
endmodule
